// File: rtl/ioctl_download_master.sv
// Initiator side of the ioctl download interface: pulls bytes from a valid/ready stream and
// writes them to a core-side loader as one ioctl_wr pulse per byte at consecutive addresses.
module ioctl_download_master #(
  parameter int unsigned ADDR_W = 25,
  parameter int unsigned WR_GAP = 1
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        index,
  input  logic [ADDR_W-1:0] len,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              ioctl_download,
  output logic [7:0]        ioctl_index,
  output logic [ADDR_W-1:0] ioctl_addr,
  output logic [7:0]        ioctl_dout,
  output logic              ioctl_wr,
  input  logic              ioctl_wait,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {StIdle, StArm, StFetch, StWrite, StGap, StTail} state_e;

  // Last value of the gap counter; GAP is never entered when WR_GAP is 0.
  localparam logic [3:0] GapLast = (WR_GAP == 0) ? 4'd0 : 4'(WR_GAP - 1);

  state_e            state_q, state_d;
  logic [7:0]        index_q, index_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        dout_q, dout_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [3:0]        gap_q, gap_d;
  logic              done_q, done_d;

  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      index_q <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    len_d    = len_q;
    addr_d   = addr_q;
    dout_d   = dout_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    done_d   = 1'b0;
    s_ready  = 1'b0;
    ioctl_wr = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          index_d = index;
          len_d   = len;
          addr_d  = '0;
          cnt_d   = '0;
          state_d = StArm;
        end
      end
      StArm: begin
        state_d = (abort || len_q == '0) ? StTail : StFetch;
      end
      StFetch: begin
        if (abort) begin
          state_d = StTail;
        end else begin
          s_ready = !ioctl_wait;
          if (s_valid && !ioctl_wait) begin
            dout_d  = s_data;
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        // A captured byte waits here with the strobe held off until the loader is ready.
        if (abort) begin
          state_d = StTail;
        end else if (!ioctl_wait) begin
          ioctl_wr = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          gap_d    = '0;
          if (cnt_d != len_q) begin
            addr_d = addr_q + 1'b1;
          end
          if (WR_GAP == 0) begin
            state_d = (cnt_d == len_q) ? StTail : StFetch;
          end else begin
            state_d = StGap;
          end
        end
      end
      StGap: begin
        if (abort) begin
          state_d = StTail;
        end else begin
          if (gap_q != GapLast) begin
            gap_d = gap_q + 1'b1;
          end else if (!ioctl_wait) begin
            state_d = (cnt_q == len_q) ? StTail : StFetch;
          end
        end
      end
      StTail: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign ioctl_download = (state_q != StIdle);
  assign busy           = (state_q != StIdle);
  assign done           = done_q;
  assign ioctl_index    = index_q;
  assign ioctl_addr     = addr_q;
  assign ioctl_dout     = dout_q;

endmodule

// File: doc/ioctl_download_master.md
Name: ioctl_download_master

Overview:
- Initiator end of the ioctl download interface. Drives ioctl_download/ioctl_index/ioctl_addr/ioctl_dout/ioctl_wr into a core-side loader and honours the loader's ioctl_wait.
- Takes bytes from a valid/ready byte stream (ROM image source, bench file reader) and emits one ioctl_wr pulse per byte at consecutive addresses.
- Used in verilator benches and on-chip self-loaders to push images into the soc.

Parameters:
- ADDR_W, 25, width of ioctl_addr and len.
- WR_GAP, 1, minimum idle cycles between ioctl_wr pulses (0..15).

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  reset; asynchronous and active-low (0 = reset).
- start  in  1  one-cycle request to begin a download; ignored while busy=1.
- index  in  8  file index; latched on accepted start.
- len  in  ADDR_W  byte count; latched on accepted start.
- abort  in  1  terminates an active download.
- s_valid  in  1  stream byte valid.
- s_data  in  8  stream byte.
- s_ready  out  1  stream byte accepted when s_valid & s_ready.
- ioctl_download  out  1  download window.
- ioctl_index  out  8  latched index.
- ioctl_addr  out  ADDR_W  byte address.
- ioctl_dout  out  8  byte data.
- ioctl_wr  out  1  one-cycle write strobe.
- ioctl_wait  in  1  loader back-pressure.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at end of download, normal or aborted.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, FSM=IDLE, counters 0.
- States: IDLE, ARM, FETCH, WRITE, GAP, TAIL.

IDLE:
- start=1 latches index and len, clears ioctl_addr, sets busy -> ARM.

ARM:
- ioctl_download goes 1 in the cycle after start and stays 1 through TAIL.
- ARM lasts exactly one cycle, with no wr.
- len=0 -> TAIL; otherwise -> FETCH.

FETCH:
- s_ready=1 only in FETCH with ioctl_wait=0.
- On handshake, capture s_data into ioctl_dout -> WRITE.

WRITE:
- ioctl_wr=1 for exactly one cycle.
- ioctl_addr and ioctl_dout stable during the pulse and held until the next handshake.
- Next state: GAP.

GAP:
- Stay at least WR_GAP cycles, and additionally while ioctl_wait=1.
- ioctl_addr increments by 1 on GAP entry, except after the last byte; this is the post-increment address for the next byte.
- Last byte, i.e. byte count reached len -> TAIL; else -> FETCH.
- WR_GAP=0: GAP lasts 0 cycles when ioctl_wait=0.

ioctl_wait:
- ioctl_wr is never asserted in a cycle where ioctl_wait=1.
- If wait rises in the same cycle as a FETCH handshake, the byte is already captured; WRITE is deferred (FSM holds in WRITE with wr=0) until wait=0.

TAIL:
- One cycle with download=1, no wr.
- Next cycle: download=0, busy=0, done=1 for one cycle -> IDLE.
- ioctl_addr retains the last written address; ioctl_index is retained.

abort (any non-IDLE state):
- Next cycle -> TAIL.
- A pending captured but unwritten byte is dropped; no further wr or handshake.
- abort and start together in IDLE: start is accepted.

Other rules:
- start while busy: ignored, no effect.
- Addresses never wrap; len is at most 2^ADDR_W−1.
- Reset mid-download: outputs drop to 0 immediately, no done pulse.

Test Plan:
- len=4, index=0x02, stream 0xA0..0xA3 always valid, WR_GAP=1, wait=0 -> 4 wr pulses at addr 0,1,2,3 with dout A0..A3 and ≥1 idle cycle between pulses; download high from cycle after start to one cycle after last GAP; done single pulse; ioctl_index=0x02.
- len=3, ioctl_wait held high for 5 cycles just after the first wr -> no wr and s_ready=0 during wait; second wr at addr 1 within WR_GAP+1 cycles of wait falling; 3 total wr.
- len=2, s_valid low for 10 cycles before each byte -> download stays high throughout; exactly 2 wr, addr 0 then 1.
- len=0 -> download high for exactly 2 cycles (ARM, TAIL), zero wr, done pulse, busy low after.
- len=100, abort after 10th wr -> at most 10 wr total; download drops within 2 cycles; done pulses once; a start pulse during the active download is ignored.
- Reset asserted (0) mid-download at byte 5 -> download, wr, busy, s_ready all 0 asynchronously; no done; a new start after release begins at addr 0.
